// File: rtl/fetch_unit_pkg.sv
// Shared types and default parameters for the instruction fetch unit.
package fetch_unit_pkg;

  // Fetch address after reset and instruction buffer depth (only 2 is supported).
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam int          DEFAULT_BUF_DEPTH = 2;

  // IDLE: leaving reset, REQ: a request may issue, WAIT: one request outstanding.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } fetch_state_e;

  // One instruction buffer entry: the fetched word and the PC it came from.
  typedef struct packed {
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misaligned;
`endif
    logic [31:0] pc;
    logic [31:0] insn;
  } buf_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of fetched {pc, insn} entries with a single-cycle flush.
// A write into a full buffer is accepted when a read completes in the same cycle.
// Flush wins over both read and write in the same cycle.
module fetch_buf
  import fetch_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       wr_en,
  input  buf_entry_t wr_data,
  input  logic       rd_en,
  output logic       valid,
  output logic [1:0] count,
  output buf_entry_t rd_data
);

  buf_entry_t mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic       full;
  logic       do_wr;
  logic       do_rd;

  assign valid   = (count != 2'd0);
  assign full    = (count == 2'd2);
  assign rd_data = mem[rd_ptr];
  assign do_rd   = rd_en && valid && !flush;
  assign do_wr   = wr_en && (!full || do_rd) && !flush;

  // Storage, pointers and occupancy; flush empties the buffer in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_rd) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_wr} - {1'b0, do_rd};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word-aligned request at a time, buffers
// responses in a 2-entry FIFO and presents them to decode in program order.
// Execute-stage redirects flush the buffer and retarget the fetch PC; a
// response still in flight at redirect time is dropped.
// Handshakes: imem request transfers when imem_req && imem_ready; exactly one
// imem_rvalid per accepted request, in order; decode consumes when
// if_valid && id_ready, and if_pc/if_insn hold steady while not consumed.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN adds if_misaligned.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = DEFAULT_BUF_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_insn,
  input  logic        id_ready
`ifdef FETCH_MISALIGN_CHECK_EN
  , output logic      if_misaligned
`endif
);

  localparam logic [1:0] BUF_CAP = 2'(BUF_DEPTH);

  fetch_state_e state, state_n;
  logic [31:0]  fetch_pc, fetch_pc_n;
  logic [31:0]  req_pc, req_pc_n;
  logic         drop, drop_n;
  logic [31:0]  redirect_target;

  logic         buf_wr;
  logic         buf_rd;
  logic         buf_valid;
  logic [1:0]   buf_count;
  buf_entry_t   wr_entry;
  buf_entry_t   head;

  // Redirect targets are always forced onto a word boundary.
  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign imem_addr       = {fetch_pc[31:2], 2'b00};

  // FSM, fetch PC, outstanding-request PC and drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      fetch_pc <= {RESET_PC[31:2], 2'b00};
      req_pc   <= '0;
      drop     <= 1'b0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      req_pc   <= req_pc_n;
      drop     <= drop_n;
    end
  end

  // Next-state, request issue and buffer write decisions.
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    req_pc_n   = req_pc;
    drop_n     = drop;
    imem_req   = 1'b0;
    buf_wr     = 1'b0;
    case (state)
      S_IDLE: begin
        state_n = S_REQ;
      end
      S_REQ: begin
        // Occupancy is the registered value: a full buffer blocks issue even
        // if decode drains an entry this cycle.
        imem_req = (buf_count < BUF_CAP) && !redirect_valid;
        if (imem_req && imem_ready) begin
          state_n    = S_WAIT;
          req_pc_n   = fetch_pc;
          fetch_pc_n = fetch_pc + 32'd4;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          // A stale response (drop set) or one racing a redirect is discarded;
          // either way the slot is free and the next request may go out.
          state_n = S_REQ;
          drop_n  = 1'b0;
          buf_wr  = !drop && !redirect_valid;
        end else if (redirect_valid) begin
          drop_n = 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    // The latest redirect always wins the fetch PC.
    if (redirect_valid) begin
      fetch_pc_n = redirect_target;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic mis_pend;

  // Remember a misaligned redirect until its first instruction is buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_pend <= 1'b0;
    end else if (redirect_valid) begin
      mis_pend <= |redirect_pc[1:0];
    end else if (buf_wr) begin
      mis_pend <= 1'b0;
    end
  end

  assign if_misaligned = buf_valid && head.misaligned;
`else
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_pc[1:0];
`endif

  // Buffer entry assembled from the outstanding request PC and returned word.
  always_comb begin
    wr_entry      = '0;
    wr_entry.pc   = req_pc;
    wr_entry.insn = imem_rdata;
`ifdef FETCH_MISALIGN_CHECK_EN
    wr_entry.misaligned = mis_pend;
`endif
  end

  assign buf_rd = if_valid && id_ready;

  fetch_buf u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redirect_valid),
    .wr_en   (buf_wr),
    .wr_data (wr_entry),
    .rd_en   (buf_rd),
    .valid   (buf_valid),
    .count   (buf_count),
    .rd_data (head)
  );

  assign if_valid = buf_valid;
  assign if_pc    = buf_valid ? head.pc   : 32'd0;
  assign if_insn  = buf_valid ? head.insn : 32'd0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency instruction memory model.
`timescale 1ns/1ps
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_insn;
  logic        id_ready;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        if_misaligned;
`endif

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_insn        (if_insn),
    .id_ready       (id_ready)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .if_misaligned (if_misaligned)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  int          lat = 1;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = '0;

  always begin
    @(negedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(paddr);
          pend        = 1'b0;
        end
      end
      if (imem_req && imem_ready) begin
        pend  = 1'b1;
        cnt   = lat;
        paddr = imem_addr;
      end
    end
  end

  // ---------------- monitors ----------------
  logic [31:0] req_log[$];
  logic [31:0] pc_log[$];
  logic [31:0] insn_log[$];

  always @(posedge clk) begin
    if (rst_n) begin
      if (imem_req && imem_ready) req_log.push_back(imem_addr);
      if (if_valid && id_ready && !redirect_valid) begin
        pc_log.push_back(if_pc);
        insn_log.push_back(if_insn);
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int req_rd   = 0;
  int dlv_rd   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int latency, input logic ready);
    @(negedge clk);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_ready     = 1'b1;
    id_ready       = ready;
    lat            = latency;
    repeat (2) @(negedge clk);
    #2;
    check("rst_imem_req", imem_req, 32'd0);
    check("rst_if_valid", if_valid, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_insn", if_insn, 32'd0);
    check("rst_state", dut.state, S_IDLE);
    check("rst_drop", dut.drop, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    req_rd = req_log.size();
    dlv_rd = pc_log.size();
    exp_q.delete();
  endtask

  task automatic wait_accepts(input int n);
    for (int k = 0; k < 60; k++) begin
      if (req_log.size() - req_rd >= n) break;
      @(negedge clk);
    end
    check("accept_wait", 32'(req_log.size() - req_rd >= n), 32'd1);
  endtask

  task automatic expect_req(input string tag, input logic [31:0] addr);
    for (int k = 0; k < 60; k++) begin
      if (req_log.size() > req_rd) break;
      @(negedge clk);
    end
    if (req_log.size() > req_rd) begin
      check(tag, req_log[req_rd], addr);
      req_rd++;
    end else begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end
  endtask

  task automatic expect_deliveries(input string tag);
    logic [31:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < 80; k++) begin
        if (pc_log.size() > dlv_rd) break;
        @(negedge clk);
      end
      if (pc_log.size() > dlv_rd) begin
        check({tag, "_pc"}, pc_log[dlv_rd], e);
        check({tag, "_insn"}, insn_log[dlv_rd], mem_word(e));
        dlv_rd++;
      end else begin
        check({tag, "_timeout"}, 32'd0, 32'd1);
      end
    end
  endtask

`ifdef FETCH_MISALIGN_CHECK_EN
  task automatic wait_valid(input string tag);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #2;
      if (if_valid) break;
    end
    check({tag, "_valid"}, if_valid, 32'd1);
  endtask
`endif

  // ---------------- directed tests ----------------
  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_ready     = 1'b1;
    id_ready       = 1'b0;

    // Straight-line fetch, 1-cycle memory, decode always ready.
    do_reset(1, 1'b1);
    repeat (2) @(negedge clk);
    #2;
    check("lat_not_yet", if_valid, 32'd0);
    @(negedge clk);
    #2;
    check("lat_valid", if_valid, 32'd1);
    check("lat_pc", if_pc, 32'h0);
    check("lat_insn", if_insn, mem_word(32'h0));
    expect_req("seq_req0", 32'h0);
    expect_req("seq_req1", 32'h4);
    expect_req("seq_req2", 32'h8);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    expect_deliveries("seq");

    // Decode stalled: buffer fills to two entries and requests stop.
    do_reset(1, 1'b0);
    repeat (8) @(negedge clk);
    #2;
    check("stall_count", dut.u_buf.count, 32'd2);
    check("stall_req", imem_req, 32'd0);
    check("stall_valid", if_valid, 32'd1);
    check("stall_pc", if_pc, 32'h0);
    check("stall_accepts", 32'(req_log.size() - req_rd), 32'd2);
    @(negedge clk);
    id_ready = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    expect_deliveries("stall");

    // Redirect while the 0x8 request is outstanding, 3-cycle memory.
    do_reset(3, 1'b1);
    wait_accepts(3);
    req_rd         = req_log.size();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    check("rd_wait_drop", dut.drop, 32'd1);
    check("rd_wait_state", dut.state, S_WAIT);
    check("rd_wait_req", imem_req, 32'd0);
    expect_req("rd_wait_req_addr", 32'h100);
    check("rd_wait_drop_clr", dut.drop, 32'd0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h100);
    expect_deliveries("rd_wait");

    // Redirect with a full buffer while decode is consuming.
    do_reset(1, 1'b0);
    repeat (8) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    id_ready       = 1'b1;
    req_rd         = req_log.size();
    dlv_rd         = pc_log.size();
    #2;
    check("rd_full_valid", if_valid, 32'd1);
    check("rd_full_req", imem_req, 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    check("rd_full_flushed", if_valid, 32'd0);
    check("rd_full_req_next", imem_req, 32'd1);
    check("rd_full_addr", imem_addr, 32'h200);
    expect_req("rd_full_req_addr", 32'h200);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    expect_deliveries("rd_full");

    // Redirect coincident with the response.
    do_reset(1, 1'b1);
    wait_accepts(1);
    req_rd         = req_log.size();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    check("rd_coin_drop", dut.drop, 32'd0);
    check("rd_coin_req", imem_req, 32'd1);
    check("rd_coin_addr", imem_addr, 32'h300);
    check("rd_coin_valid", if_valid, 32'd0);
    expect_req("rd_coin_req_addr", 32'h300);
    exp_q.push_back(32'h300);
    expect_deliveries("rd_coin");

    // Back-to-back redirects while waiting: the later, misaligned one wins.
    do_reset(3, 1'b1);
    wait_accepts(1);
    req_rd         = req_log.size();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    @(negedge clk);
    redirect_pc    = 32'h502;
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    check("rd_twice_drop", dut.drop, 32'd1);
    expect_req("rd_twice_req_addr", 32'h500);
    exp_q.push_back(32'h500);
    exp_q.push_back(32'h504);
    expect_deliveries("rd_twice");

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned redirect flags only the first instruction.
    do_reset(1, 1'b1);
    wait_accepts(1);
    req_rd         = req_log.size();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    check("mis_addr", imem_addr, 32'h100);
    wait_valid("mis_first");
    check("mis_first_pc", if_pc, 32'h100);
    check("mis_first_flag", if_misaligned, 32'd1);
    wait_valid("mis_second");
    check("mis_second_pc", if_pc, 32'h104);
    check("mis_second_flag", if_misaligned, 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
